// File: rtl/modexp_engine.sv
// Modular exponentiation, right-to-left square-and-multiply, one exponent bit per cycle.
// Optional MODEXP_EARLY_EXIT_EN: stop RUN once the remaining exponent bits are all zero.
module modexp_engine #(
    parameter int WIDTH     = 16,
    parameter int EXP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     modulus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 err,
    output logic                 busy
);

    localparam int CW = $clog2(EXP_WIDTH) + 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]     m_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]     result_q;
    logic [EXP_WIDTH-1:0] e_q;
    logic [CW-1:0]        cnt_q;
    logic                 err_q;

    logic                 accept;
    logic                 m_zero;
    logic                 run_last;
    logic [WIDTH-1:0]     m_safe;
    logic [PW-1:0]        m_ext;
    logic [PW-1:0]        acc_ext;
    logic [PW-1:0]        b_ext;
    logic [WIDTH-1:0]     acc_mul;
    logic [WIDTH-1:0]     b_sq;
    logic [WIDTH-1:0]     acc_next;
    logic [WIDTH-1:0]     acc_init;
    logic [WIDTH-1:0]     b_init;

    assign accept = in_valid && (state_q == IDLE);
    assign m_zero = (m_q == '0);

    // Divisor forced non-zero so the remainder logic never sees 0;
    // the modulus-0 path bypasses these results entirely.
    assign m_safe = m_zero ? WIDTH'(1) : m_q;
    assign m_ext  = {{WIDTH{1'b0}}, m_safe};
    assign acc_ext = {{WIDTH{1'b0}}, acc_q};
    assign b_ext   = {{WIDTH{1'b0}}, b_q};

    assign acc_mul  = WIDTH'((acc_ext * b_ext) % m_ext);
    assign b_sq     = WIDTH'((b_ext * b_ext) % m_ext);
    assign acc_next = e_q[0] ? acc_mul : acc_q;
    assign acc_init = WIDTH'(1) % m_safe;
    assign b_init   = b_q % m_safe;

`ifdef MODEXP_EARLY_EXIT_EN
    assign run_last = ((e_q >> 1) == '0)
                   || (cnt_q == CW'(EXP_WIDTH - 1));
`else
    assign run_last = (cnt_q == CW'(EXP_WIDTH - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = LOAD;
            LOAD: state_d = m_zero ? DONE : RUN;
            RUN:  if (run_last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            e_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                m_q <= modulus;
                b_q <= base;
                e_q <= exponent;
            end
            if (state_q == LOAD) begin
                acc_q <= acc_init;
                b_q   <= b_init;
                cnt_q <= '0;
                if (m_zero) begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end
            end
            if (state_q == RUN) begin
                acc_q <= acc_next;
                b_q   <= b_sq;
                e_q   <= e_q >> 1;
                cnt_q <= cnt_q + CW'(1);
                // Final product goes straight into result on the DONE edge
                if (run_last) begin
                    result_q <= acc_next;
                    err_q    <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == LOAD) || (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_modexp_engine.sv
// Self-checking bench for modexp_engine against a repeated-multiplication model.
// Honours MODEXP_EARLY_EXIT_EN when computing expected latency.
module tb_modexp_engine;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] base;
    logic [15:0] exponent;
    logic [15:0] modulus;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        err;
    logic        busy;

    int checks;
    int failures;

    modexp_engine #(.WIDTH(16), .EXP_WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .base     (base),
        .exponent (exponent),
        .modulus  (modulus),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_modexp(
        input logic [15:0] b,
        input logic [15:0] e,
        input logic [15:0] m
    );
        longint r;
        if (m == 0) return 16'd0;
        r = 1 % longint'(m);
        for (int i = 0; i < int'(e); i++)
            r = (r * longint'(b)) % longint'(m);
        return 16'(r);
    endfunction

    function automatic int ref_lat(
        input logic [15:0] e,
        input logic [15:0] m
    );
        int n;
        if (m == 0) return 1;
        n = 16;
`ifdef MODEXP_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 16; i++)
            if (e[i]) n = i + 1;
`endif
        return n + 1;
    endfunction

    task automatic start_op(
        input logic [15:0] b,
        input logic [15:0] e,
        input logic [15:0] m,
        output bit         ok
    );
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        ok = in_ready;
        if (!ok) return;
        in_valid = 1'b1;
        base     = b;
        exponent = e;
        modulus  = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        base     = 16'($urandom);
        exponent = 16'($urandom);
        modulus  = 16'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic do_op(
        input  logic [15:0] b,
        input  logic [15:0] e,
        input  logic [15:0] m,
        input  int          hold,
        output int          lat,
        output logic [15:0] res,
        output logic        er
    );
        bit ok;
        start_op(b, e, m, ok);
        if (!ok) begin
            lat = -1; res = 'x; er = 'x;
            return;
        end
        wait_out(lat);
        res = result;
        er  = err;
        if (lat < 0) return;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        base      = '0;
        exponent  = '0;
        modulus   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks += 5;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        if (result !== 16'd0) begin
            failures++;
            $display("FAIL reset_result got=%0d exp=0", result);
        end
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got=%b exp=0", err);
        end
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_vectors;
        logic [15:0] tb_b [7];
        logic [15:0] tb_e [7];
        logic [15:0] tb_m [7];
        logic [15:0] tb_r [7];
        logic        tb_er[7];
        int          lat;
        logic [15:0] res;
        logic        er;
        tb_b = '{16'd65, 16'd2790, 16'd3298, 16'd5, 16'd777, 16'd0, 16'd1234};
        tb_e = '{16'd17, 16'd2753, 16'd17, 16'd0, 16'd99, 16'd5, 16'd3};
        tb_m = '{16'd3233, 16'd3233, 16'd3233, 16'd3233, 16'd1, 16'd3233, 16'd0};
        tb_r = '{16'd2790, 16'd65, 16'd2790, 16'd1, 16'd0, 16'd0, 16'd0};
        tb_er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            do_op(tb_b[i], tb_e[i], tb_m[i], 0, lat, res, er);
            checks += 3;
            if (lat !== ref_lat(tb_e[i], tb_m[i])) begin
                failures++;
                $display("FAIL vec%0d_latency got=%0d exp=%0d",
                         i, lat, ref_lat(tb_e[i], tb_m[i]));
            end
            if (res !== tb_r[i]) begin
                failures++;
                $display("FAIL vec%0d_result got=%0d exp=%0d",
                         i, res, tb_r[i]);
            end
            if (er !== tb_er[i]) begin
                failures++;
                $display("FAIL vec%0d_err got=%b exp=%b", i, er, tb_er[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        int lat;
        start_op(16'd65, 16'd17, 16'd3233, ok);
        wait_out(lat);
        checks++;
        if (!ok || lat !== ref_lat(16'd17, 16'd3233)) begin
            failures++;
            $display("FAIL bp_latency got=%0d exp=%0d",
                     lat, ref_lat(16'd17, 16'd3233));
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (result !== 16'd2790 || out_valid !== 1'b1
                || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d result=%0d ov=%b ir=%b exp=2790/1/0",
                         i, result, out_valid, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks += 2;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release_out_valid got=%b exp=0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        bit          ok;
        int          lat;
        logic [15:0] res;
        logic        er;
        start_op(16'd65, 16'd17, 16'd3233, ok);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks += 2;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL rmid_busy got=%b exp=0", busy);
        end
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rmid_out_valid got=%b exp=0", out_valid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rmid_idle%0d ir=%b ov=%b busy=%b exp=1/0/0",
                         i, in_ready, out_valid, busy);
            end
            @(posedge clk); #1;
        end
        do_op(16'd65, 16'd17, 16'd3233, 1, lat, res, er);
        checks += 2;
        if (res !== 16'd2790 || er !== 1'b0) begin
            failures++;
            $display("FAIL rmid_rerun got=%0d/%b exp=2790/0", res, er);
        end
        if (lat !== ref_lat(16'd17, 16'd3233)) begin
            failures++;
            $display("FAIL rmid_rerun_latency got=%0d exp=%0d",
                     lat, ref_lat(16'd17, 16'd3233));
        end
    endtask

    task automatic test_sweep;
        int          lat;
        logic [15:0] res;
        logic        er;
        logic [15:0] exp_r;
        for (int b = 0; b < 256; b++) begin
            do_op(16'(b), 16'd17, 16'd3233, int'($urandom_range(0, 3)),
                  lat, res, er);
            exp_r = ref_modexp(16'(b), 16'd17, 16'd3233);
            checks++;
            if (res !== exp_r || er !== 1'b0 || lat < 0) begin
                failures++;
                $display("FAIL sweep_b%0d got=%0d err=%b lat=%0d exp=%0d",
                         b, res, er, lat, exp_r);
            end
        end
    endtask

    task automatic test_random;
        int          lat;
        logic [15:0] res;
        logic        er;
        logic [15:0] b, e, m;
        for (int i = 0; i < 25; i++) begin
            b = 16'($urandom);
            e = (i % 3 == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            m = 16'($urandom_range(1, 65535));
            do_op(b, e, m, int'($urandom_range(0, 2)), lat, res, er);
            checks += 2;
            if (res !== ref_modexp(b, e, m) || er !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d %0d^%0d mod %0d got=%0d err=%b exp=%0d",
                         i, b, e, m, res, er, ref_modexp(b, e, m));
            end
            if (lat !== ref_lat(e, m)) begin
                failures++;
                $display("FAIL rand%0d_latency got=%0d exp=%0d",
                         i, lat, ref_lat(e, m));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_run();
        test_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
